// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings: transfer types, responses, data-phase owner select.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    SEL_SLV0 = 3'd0,
    SEL_SLV1 = 3'd1,
    SEL_SLV2 = 3'd2,
    SEL_SLV3 = 3'd3,
    SEL_DFLT = 3'd4,
    SEL_NONE = 3'd5
  } sel_e;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

  // Lowest-numbered select wins; unmapped active transfers go to the default slave.
  function automatic sel_e encode_sel(input logic [3:0] hsel, input logic [1:0] htrans);
    if (hsel[0])      return SEL_SLV0;
    else if (hsel[1]) return SEL_SLV1;
    else if (hsel[2]) return SEL_SLV2;
    else if (hsel[3]) return SEL_SLV3;
    else if (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ) return SEL_DFLT;
    else              return SEL_NONE;
  endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave for unmapped addresses: two-cycle ERROR response, registered outputs.
module ahb_default_slave
  import ahb_pkg::*;
(
  input  logic HCLK,
  input  logic HRESET,
  input  logic HREADY,
  input  logic capture_dflt,
  output logic ds_hready,
  output logic ds_hresp
);

  ds_state_e state;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= DS_IDLE;
      ds_hready <= 1'b1;
      ds_hresp  <= RESP_OKAY;
    end else begin
      case (state)
        // ERR2 completes the transfer, so it may start the next one like IDLE does.
        DS_IDLE, DS_ERR2: begin
          if (HREADY && capture_dflt) begin
            state     <= DS_ERR1;
            ds_hready <= 1'b0;
            ds_hresp  <= RESP_ERROR;
          end else begin
            state     <= DS_IDLE;
            ds_hready <= 1'b1;
            ds_hresp  <= RESP_OKAY;
          end
        end
        DS_ERR1: begin
          state     <= DS_ERR2;
          ds_hready <= 1'b1;
          ds_hresp  <= RESP_ERROR;
        end
        default: begin
          state     <= DS_IDLE;
          ds_hready <= 1'b1;
          ds_hresp  <= RESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahb_slave_mux.sv
// AHB-Lite response mux: registers the decoded select in the address phase and
// steers the owning slave's response (or the default slave's) in the data phase.
module ahb_slave_mux
  import ahb_pkg::*;
#(
  parameter int          DW        = 32,
  parameter logic [DW-1:0] ERR_RDATA = 32'hDEAD_BEEF
) (
  input  logic          HCLK,
  input  logic          HRESET,
  input  logic          HSELx0,
  input  logic          HSELx1,
  input  logic          HSELx2,
  input  logic          HSELx3,
  input  logic [1:0]    HTRANS,
  input  logic [DW-1:0] HRDATAx0,
  input  logic [DW-1:0] HRDATAx1,
  input  logic [DW-1:0] HRDATAx2,
  input  logic [DW-1:0] HRDATAx3,
  input  logic          HREADYOUTx0,
  input  logic          HREADYOUTx1,
  input  logic          HREADYOUTx2,
  input  logic          HREADYOUTx3,
  input  logic          HRESPx0,
  input  logic          HRESPx1,
  input  logic          HRESPx2,
  input  logic          HRESPx3,
  output logic [DW-1:0] HRDATA,
  output logic          HREADY,
  output logic          HRESP
);

  sel_e sel_d;
  sel_e sel_q;
  logic ds_hready;
  logic ds_hresp;

  assign sel_d = encode_sel({HSELx3, HSELx2, HSELx1, HSELx0}, HTRANS);

  // Address phase: capture owner only when the previous data phase completes.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET)      sel_q <= SEL_NONE;
    else if (HREADY) sel_q <= sel_d;
  end

  ahb_default_slave u_default_slave (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HREADY       (HREADY),
    .capture_dflt (sel_d == SEL_DFLT),
    .ds_hready    (ds_hready),
    .ds_hresp     (ds_hresp)
  );

  // Data phase: only the owner's signals reach the master, so an idle slave's X never leaks.
  always_comb begin
    HRDATA = ERR_RDATA;
    HREADY = 1'b1;
    HRESP  = RESP_OKAY;
    case (sel_q)
      SEL_SLV0: begin HRDATA = HRDATAx0; HREADY = HREADYOUTx0; HRESP = HRESPx0; end
      SEL_SLV1: begin HRDATA = HRDATAx1; HREADY = HREADYOUTx1; HRESP = HRESPx1; end
      SEL_SLV2: begin HRDATA = HRDATAx2; HREADY = HREADYOUTx2; HRESP = HRESPx2; end
      SEL_SLV3: begin HRDATA = HRDATAx3; HREADY = HREADYOUTx3; HRESP = HRESPx3; end
      // An idle FSM drives 1/OKAY, which matches the NONE response.
      SEL_DFLT: begin HREADY = ds_hready; HRESP = ds_hresp; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Bench for ahb_slave_mux: directed scenarios plus random traffic against a
// transaction-level model of who owns the current data phase.
module tb_ahb_slave_mux;

  localparam int          DW  = 32;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam int OWN_DFLT = 4;
  localparam int OWN_NONE = 5;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          HSELx0, HSELx1, HSELx2, HSELx3;
  logic [1:0]    HTRANS;
  logic [DW-1:0] rd  [4];
  logic          rdy [4];
  logic          rsp [4];
  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic          HRESP;

  int n_chk  = 0;
  int n_fail = 0;
  int owner  = OWN_NONE;   // who owns the current data phase
  int errc   = 0;          // index within the default slave's two-cycle ERROR

  always #5 HCLK = ~HCLK;

  ahb_slave_mux #(.DW(DW), .ERR_RDATA(ERR)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .HSELx0(HSELx0), .HSELx1(HSELx1), .HSELx2(HSELx2), .HSELx3(HSELx3),
    .HTRANS(HTRANS),
    .HRDATAx0(rd[0]), .HRDATAx1(rd[1]), .HRDATAx2(rd[2]), .HRDATAx3(rd[3]),
    .HREADYOUTx0(rdy[0]), .HREADYOUTx1(rdy[1]), .HREADYOUTx2(rdy[2]), .HREADYOUTx3(rdy[3]),
    .HRESPx0(rsp[0]), .HRESPx1(rsp[1]), .HRESPx2(rsp[2]), .HRESPx3(rsp[3]),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [3:0] sel, input logic [1:0] tr);
    for (int i = 0; i < 4; i++) if (sel[i]) return i;
    return tr[1] ? OWN_DFLT : OWN_NONE;
  endfunction

  task automatic expected(output logic [31:0] d, output logic r, output logic s);
    if (owner < 4) begin
      d = rd[owner]; r = rdy[owner]; s = rsp[owner];
    end else if (owner == OWN_DFLT) begin
      d = ERR; r = (errc == 1); s = 1'b1;
    end else begin
      d = ERR; r = 1'b1; s = 1'b0;
    end
  endtask

  task automatic slaves_idle();
    for (int i = 0; i < 4; i++) begin
      rd[i] = 32'h1000_0000 + i; rdy[i] = 1'b1; rsp[i] = 1'b0;
    end
  endtask

  // One bus cycle: drive address phase, check data-phase outputs, advance the model.
  task automatic step(input logic [3:0] sel, input logic [1:0] tr, input string tag);
    logic [31:0] ed;
    logic        er, es;
    {HSELx3, HSELx2, HSELx1, HSELx0} = sel;
    HTRANS = tr;
    @(negedge HCLK);
    expected(ed, er, es);
    check({tag, ".hrdata"}, HRDATA, ed);
    check({tag, ".hready"}, {31'd0, HREADY}, {31'd0, er});
    check({tag, ".hresp"},  {31'd0, HRESP},  {31'd0, es});
    @(posedge HCLK);
    if (er) begin
      owner = decode(sel, tr);
      errc  = 0;
    end else if (owner == OWN_DFLT) begin
      errc = 1;
    end
    #1;
  endtask

  initial begin
    HRESET = 1'b1;
    {HSELx3, HSELx2, HSELx1, HSELx0} = 4'b0;
    HTRANS = 2'b00;
    slaves_idle();
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    check("por.hrdata", HRDATA, ERR);
    check("por.hready", {31'd0, HREADY}, 32'd1);
    check("por.hresp",  {31'd0, HRESP},  32'd0);
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Reset while slave1 stalls its data phase
    step(4'b0010, 2'b10, "t1.addr");
    rdy[1] = 1'b0; rd[1] = 32'hAAAA_5555;
    step(4'b0000, 2'b00, "t1.stall");
    HRESET = 1'b1;
    @(negedge HCLK);
    check("t1.rst.hrdata", HRDATA, ERR);
    check("t1.rst.hready", {31'd0, HREADY}, 32'd1);
    check("t1.rst.hresp",  {31'd0, HRESP},  32'd0);
    HRESET = 1'b0;
    owner = OWN_NONE; errc = 0;
    @(posedge HCLK); #1;
    slaves_idle();

    // Slave2 read with two wait states
    step(4'b0100, 2'b10, "t2.addr");
    rd[2] = 32'h1234_5678; rdy[2] = 1'b0;
    step(4'b0000, 2'b00, "t2.wait1");
    step(4'b0000, 2'b00, "t2.wait2");
    rdy[2] = 1'b1;
    step(4'b0000, 2'b00, "t2.done");

    // Unmapped NONSEQ, then unmapped IDLE
    step(4'b0000, 2'b10, "t3.addr");
    step(4'b0000, 2'b00, "t3.err1");
    step(4'b0000, 2'b00, "t3.err2");
    step(4'b0000, 2'b00, "t4.idle");
    step(4'b0000, 2'b01, "t4.busy");

    // slave0 -> unmapped -> slave3 back to back
    rd[0] = 32'h0000_C0DE; rd[3] = 32'h3333_F00D;
    step(4'b0001, 2'b10, "t5.s0");
    step(4'b0000, 2'b10, "t5.dflt");
    step(4'b1000, 2'b10, "t5.err1");
    step(4'b1000, 2'b10, "t5.err2");
    step(4'b0000, 2'b00, "t5.s3");

    // Two unmapped NONSEQ back to back, with a cancel (IDLE) during ERR1
    step(4'b0000, 2'b10, "t6.a");
    step(4'b0000, 2'b11, "t6.err1a");
    step(4'b0000, 2'b11, "t6.err2a");
    step(4'b0000, 2'b00, "t6.err1b");
    step(4'b0000, 2'b00, "t6.err2b");
    step(4'b0000, 2'b00, "t6.tail");

    // Random traffic: one-hot or no select, random slave responses
    for (int n = 0; n < 400; n++) begin
      int          pick;
      logic [3:0]  sel;
      pick = $urandom_range(0, 6);
      sel  = (pick < 4) ? (4'b0001 << pick) : 4'b0000;
      for (int i = 0; i < 4; i++) begin
        rd[i]  = $urandom;
        rdy[i] = ($urandom_range(0, 3) != 0);
        rsp[i] = ($urandom_range(0, 7) == 0);
      end
      step(sel, 2'($urandom_range(0, 3)), "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
